multi_debouncer: RTL

Parametrised, multi-channel successor to the single-input push-button debouncer. Each channel synchronises an asynchronous raw input, filters it with a programmable stability window, and emits a clean level plus one-cycle press and release pulses. It also provides an optional auto-repeat pulse train while a button is held. It sits between the board buttons/switches and the stopwatch control FSM, replacing per-button debouncer instances.

---
 rtl/multi_debouncer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multi_debouncer.sv
// ============================================================================
// multi_debouncer : per-channel synchroniser, stability-window debouncer,
//                   press/release pulses and optional auto-repeat strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt,
  output logic [CHANNELS-1:0] act
);

  localparam int c_DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int c_RW   = $clog2(c_RMAX + 1);

  localparam logic [c_DW-1:0] c_DB_LAST  = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RW-1:0] c_HOLD_END = c_RW'(HOLD_CYCLES);
  localparam logic [c_RW-1:0] c_RPT_END  = c_RW'(REPEAT_CYCLES - 1);
  localparam logic            c_RPT_EN   = (HOLD_CYCLES > 0);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_HOLD   = 2'd1;
  localparam logic [1:0] c_REPEAT = 2'd2;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic            r_s0, r_s1, r_clean, r_rise, r_fall, r_rpt, r_act;
    logic [c_DW-1:0] r_dcnt;
    logic [1:0]      r_state, w_state_nxt;
    logic [c_RW-1:0] r_rcnt, w_rcnt_nxt;
    logic            w_accept, w_rise_cond, w_fall_cond, w_rpt_nxt;

    // A new level is accepted on the edge that completes the stability window.
    assign w_accept    = (r_s1 != r_clean) && (r_dcnt == c_DB_LAST);
    assign w_rise_cond = w_accept & r_s1;
    assign w_fall_cond = w_accept & ~r_s1;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s0    <= 1'b0;
        r_s1    <= 1'b0;
        r_clean <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_dcnt  <= '0;
      end else begin
        r_s0   <= raw[gi];
        r_s1   <= r_s0;
        r_rise <= w_rise_cond;
        r_fall <= w_fall_cond;
        if (r_s1 == r_clean) begin
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_clean <= r_s1;
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + c_DW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= c_IDLE;
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
        r_act   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_rpt   <= w_rpt_nxt;
        r_act   <= w_rise_cond | w_rpt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      case (r_state)
        c_IDLE: begin
          if (w_rise_cond && c_RPT_EN) begin
            w_state_nxt = c_HOLD;
            w_rcnt_nxt  = c_RW'(1);
          end
        end
        c_HOLD: begin
          if (w_fall_cond) begin
            w_state_nxt = c_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == c_HOLD_END) begin
            w_state_nxt = c_REPEAT;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + c_RW'(1);
          end
        end
        c_REPEAT: begin
          if (w_fall_cond) begin
            w_state_nxt = c_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == c_RPT_END) begin
            w_rcnt_nxt = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + c_RW'(1);
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end

    // A release accepted on the same edge suppresses the repeat strobe.
    always_comb begin
      w_rpt_nxt = 1'b0;
      case (r_state)
        c_HOLD:   w_rpt_nxt = ~w_fall_cond && (r_rcnt == c_HOLD_END);
        c_REPEAT: w_rpt_nxt = ~w_fall_cond && (r_rcnt == c_RPT_END);
        default:  w_rpt_nxt = 1'b0;
      endcase
    end

    assign clean[gi] = r_clean;
    assign rise[gi]  = r_rise;
    assign fall[gi]  = r_fall;
    assign rpt[gi]   = r_rpt;
    assign act[gi]   = r_act;
  end

endmodule

`default_nettype wire
